// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate-network stimulus sequencer.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } gate_seq_state_e;

  localparam int NUM_VEC   = 4;
  localparam int VEC_IDX_W = 2;
  localparam int ERR_W     = 3;

  // Mismatch counter increment that stops at NUM_VEC so the 3-bit count never wraps.
  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] e);
    logic [ERR_W-1:0] r;
    if (e >= ERR_W'(NUM_VEC)) begin
      r = ERR_W'(NUM_VEC);
    end else begin
      r = e + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gate_dut_sequencer_sync_2ff.sv
// Module sync_2ff: 1-bit two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic ff1_r;
  logic ff2_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_r <= 1'b0;
      ff2_r <= 1'b0;
    end else begin
      ff1_r <= d;
      ff2_r <= ff1_r;
    end
  end

  assign q = ff2_r;

endmodule

// File: rtl/gate_dut_sequencer.sv
// Steps a two-input gate network through all four vectors and checks out1 against EXPECT.
// Optional: GATE_SEQ_SYNC_IN_EN adds a two-flop synchronizer on dut_out and lengthens each window.
import gate_seq_pkg::*;

module gate_dut_sequencer #(
  parameter logic [NUM_VEC-1:0] EXPECT     = 4'b1111,
  parameter int                 SETTLE_CYC = 3,
  parameter int                 CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_out,
  output logic             dut_in1,
  output logic             dut_in2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [NUM_VEC-1:0] fail_vec
);

  localparam int SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;

  logic sample_s;

`ifdef GATE_SEQ_SYNC_IN_EN
  // Two extra window cycles let the synchronizer catch up with the new vector.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF + 1);

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (sample_s)
  );
`else
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);

  assign sample_s = dut_out;
`endif

  gate_seq_state_e        state_r,    state_nx_s;
  logic [CNT_W-1:0]       cnt_r,      cnt_nx_s;
  logic [VEC_IDX_W-1:0]   idx_r,      idx_nx_s;
  logic [ERR_W-1:0]       err_r,      err_nx_s;
  logic [NUM_VEC-1:0]     fail_r,     fail_nx_s;
  logic                   pass_r,     pass_nx_s;
  logic                   done_r,     done_nx_s;
  logic                   busy_r,     busy_nx_s;

  // Next-state and next-output computation for the sequencing FSM.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    idx_nx_s   = idx_r;
    err_nx_s   = err_r;
    fail_nx_s  = fail_r;
    pass_nx_s  = pass_r;
    done_nx_s  = 1'b0;
    busy_nx_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_nx_s = SETTLE;
          idx_nx_s   = 2'd0;
          cnt_nx_s   = CNT_LOAD;
          err_nx_s   = 3'd0;
          fail_nx_s  = 4'd0;
          pass_nx_s  = 1'b0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nx_s = IDLE;
          idx_nx_s   = 2'd0;
          pass_nx_s  = 1'b0;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_nx_s = SAMPLE;
        end else begin
          cnt_nx_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nx_s = IDLE;
          idx_nx_s   = 2'd0;
          pass_nx_s  = 1'b0;
        end else begin
          if (sample_s != EXPECT[idx_r]) begin
            err_nx_s         = err_sat_inc(err_r);
            fail_nx_s[idx_r] = 1'b1;
          end else begin
            err_nx_s = err_r;
          end
          // Last vector ends the run instead of wrapping the index.
          if (idx_r == VEC_IDX_W'(NUM_VEC - 1)) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = SETTLE;
            idx_nx_s   = idx_r + 2'd1;
            cnt_nx_s   = CNT_LOAD;
          end
        end
      end
      DONE: begin
        state_nx_s = IDLE;
        done_nx_s  = 1'b1;
        pass_nx_s  = (err_r == 3'd0);
      end
      default: begin
        state_nx_s = IDLE;
        idx_nx_s   = 2'd0;
      end
    endcase

    busy_nx_s = (state_nx_s == SETTLE) || (state_nx_s == SAMPLE);
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= 2'd0;
      err_r   <= 3'd0;
      fail_r  <= 4'd0;
      pass_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      idx_r   <= idx_nx_s;
      err_r   <= err_nx_s;
      fail_r  <= fail_nx_s;
      pass_r  <= pass_nx_s;
      done_r  <= done_nx_s;
      busy_r  <= busy_nx_s;
    end
  end

  assign dut_in1  = idx_r[1];
  assign dut_in2  = idx_r[0];
  assign busy     = busy_r;
  assign done     = done_r;
  assign pass     = pass_r;
  assign err_cnt  = err_r;
  assign fail_vec = fail_r;

endmodule

// File: tb/tb_gate_dut_sequencer.sv
// Self-checking bench for gate_dut_sequencer: directed and random runs against a vector-level model.
module tb_gate_dut_sequencer;

  localparam logic [3:0] EXP_TT = 4'b1111;
  localparam int SC = 3;
`ifdef GATE_SEQ_SYNC_IN_EN
  localparam int P = SC + 3;
`else
  localparam int P = SC + 1;
`endif
  localparam int L = 4 * P + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       dut_out;
  logic       dut_in1;
  logic       dut_in2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;

  logic [3:0] resp;
  logic       glitch;

  int n_checks = 0;
  int n_fail   = 0;

  gate_dut_sequencer #(
    .EXPECT     (EXP_TT),
    .SETTLE_CYC (SC),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .dut_out  (dut_out),
    .dut_in1  (dut_in1),
    .dut_in2  (dut_in2),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_vec (fail_vec)
  );

  always #5 clk = ~clk;

  // The emulated gate network answers with resp[vector], optionally glitched.
  assign dut_out = resp[{dut_in1, dut_in2}] ^ glitch;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One run from IDLE; checks every cycle up to one past the done pulse.
  task automatic run_seq(input logic [3:0] r, input bit glitch_en, input bit restart_en,
                         input bit abort_en);
    int  completed;
    int  exp_err;
    logic [3:0] exp_fail;
    bit  aborted;
    bit  exp_busy;
    int  exp_idx;
    completed = abort_en ? 1 : 4;
    exp_err   = 0;
    exp_fail  = 4'd0;
    for (int v = 0; v < completed; v++) begin
      if (r[v] != EXP_TT[v]) begin
        exp_err++;
        exp_fail[v] = 1'b1;
      end
    end
    @(negedge clk);
    resp  = r;
    start = 1'b1;
    for (int c = 0; c <= L + 1; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      aborted  = abort_en && (c >= P + 2);
      exp_busy = !aborted && (c < 4 * P);
      exp_idx  = aborted ? 0 : c / P;
      chk("busy", {7'd0, busy}, {7'd0, exp_busy});
      chk("done", {7'd0, done}, {7'd0, (!abort_en && c == L)});
      if (aborted || c < 4 * P) begin
        chk("dut_in", {6'd0, dut_in1, dut_in2}, 8'(exp_idx));
      end
      if (glitch_en && c == P + 1) glitch = 1'b1;
      if (glitch_en && c == P + 2) glitch = 1'b0;
      if (abort_en && c == P + 1) abort = 1'b1;
      if (abort_en && c == P + 2) abort = 1'b0;
      if (restart_en && c == 2 * P + 1) start = 1'b1;
      if (restart_en && c == 2 * P + 2) start = 1'b0;
    end
    chk("err_cnt", {5'd0, err_cnt}, 8'(exp_err));
    chk("fail_vec", {4'd0, fail_vec}, {4'd0, exp_fail});
    chk("pass", {7'd0, pass}, {7'd0, (!abort_en && exp_err == 0)});
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    resp   = 4'b1111;
    glitch = 1'b0;
    #12;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_pass", {7'd0, pass}, 8'd0);
    chk("rst_err", {5'd0, err_cnt}, 8'd0);
    chk("rst_fail", {4'd0, fail_vec}, 8'd0);
    chk("rst_in", {6'd0, dut_in1, dut_in2}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_seq(4'b1111, 1'b0, 1'b0, 1'b0);
    run_seq(4'b1011, 1'b0, 1'b0, 1'b0);
    run_seq(4'b1111, 1'b1, 1'b0, 1'b0);
    run_seq(4'b1110, 1'b0, 1'b0, 1'b1);

    // start together with abort in IDLE must not launch a run
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", {7'd0, busy}, 8'd0);
    repeat (3) @(negedge clk);
    chk("sa_busy2", {7'd0, busy}, 8'd0);
    chk("sa_done", {7'd0, done}, 8'd0);

    run_seq(4'b0111, 1'b0, 1'b1, 1'b0);
    run_seq(4'b0000, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_seq(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'b0);
    end

    // asynchronous reset mid-run, between clock edges
    @(negedge clk);
    resp  = 4'b1010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (P + 1) @(negedge clk);
    chk("pre_rst_busy", {7'd0, busy}, 8'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_done", {7'd0, done}, 8'd0);
    chk("arst_pass", {7'd0, pass}, 8'd0);
    chk("arst_err", {5'd0, err_cnt}, 8'd0);
    chk("arst_fail", {4'd0, fail_vec}, 8'd0);
    chk("arst_in", {6'd0, dut_in1, dut_in2}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(4'b0111, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
